// File: rtl/regfile_pkg.sv
// Shared register-file types and constants; reg_idx_t is also used by the
// processor's decode logic so index widths cannot drift apart.
package regfile_pkg;

  localparam int REG_COUNT = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = 5'd0;

  // One-hot decode of a register index into a REG_COUNT-wide select vector.
  function automatic logic [REG_COUNT-1:0] idx_onehot(input reg_idx_t idx);
    logic [REG_COUNT-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/regfile_word.sv
// One architectural register: a DATA_W flop bank with write enable and
// asynchronous active-high clear.
module regfile_word #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;

  // NOTE: default assignment first so every path drives data_d (no latch).
  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      data_d = wr_data;
    end
  end

  // NOTE: each word is a real flop bank (not a RAM macro), so it can and must
  // be cleared by reset; non-blocking keeps all words updating in lockstep.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign rd_data = data_q;

endmodule

// File: rtl/regfile.sv
// Thirty-two-entry register file: r0 hardwired to zero, two combinational
// read ports, one clocked write port, optional write-through bypass.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int WRITE_THROUGH = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ctrl_writeEnable,
  input  reg_idx_t          ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  reg_idx_t          ctrl_readRegA,
  input  reg_idx_t          ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB
);

  logic [REG_COUNT-1:1] wr_sel;
  logic [REG_COUNT-1:0] rd_sel_a;
  logic [REG_COUNT-1:0] rd_sel_b;
  logic [DATA_W-1:0]    reg_val [REG_COUNT];
  logic [DATA_W-1:0]    stored_a;
  logic [DATA_W-1:0]    stored_b;
  logic                 bypass_a;
  logic                 bypass_b;

  // Write decoder; there is no bit 0, so writes to r0 fall on the floor.
  always_comb begin
    wr_sel = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      wr_sel[i] = ctrl_writeEnable && (ctrl_writeReg == reg_idx_t'(i));
    end
  end

  for (genvar i = 0; i < REG_COUNT; i++) begin : g_word
    if (i == 0) begin : g_zero
      assign reg_val[i] = '0;
    end else begin : g_reg
      regfile_word #(
        .DATA_W (DATA_W)
      ) u_word (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_sel[i]),
        .wr_data (data_writeReg),
        .rd_data (reg_val[i])
      );
    end
  end

  assign rd_sel_a = idx_onehot(ctrl_readRegA);
  assign rd_sel_b = idx_onehot(ctrl_readRegB);

  // AND-OR read selects; reg_val[0] is constant zero so index 0 reads 0.
  always_comb begin
    stored_a = '0;
    stored_b = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      stored_a = stored_a | ({DATA_W{rd_sel_a[i]}} & reg_val[i]);
      stored_b = stored_b | ({DATA_W{rd_sel_b[i]}} & reg_val[i]);
    end
  end

  // Bypass is masked by reset so outputs read zero throughout reset.
  always_comb begin
    bypass_a = (WRITE_THROUGH != 0) && !reset && ctrl_writeEnable &&
               (ctrl_readRegA == ctrl_writeReg) && (ctrl_readRegA != ZERO_REG);
    bypass_b = (WRITE_THROUGH != 0) && !reset && ctrl_writeEnable &&
               (ctrl_readRegB == ctrl_writeReg) && (ctrl_readRegB != ZERO_REG);
  end

  always_comb begin
    data_readRegA = bypass_a ? data_writeReg : stored_a;
    data_readRegB = bypass_b ? data_writeReg : stored_b;
  end

endmodule

// File: tb/tb_regfile.sv
// Scoreboarded bench for regfile: one write-through and one plain instance
// share stimulus; a monitor pops expected reads and compares both.
`timescale 1ns/1ps
module tb_regfile;

  typedef struct {
    string       name;
    logic [31:0] a_wt;
    logic [31:0] b_wt;
    logic [31:0] a_nwt;
    logic [31:0] b_nwt;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [31:0] a_wt, b_wt, a_nwt, b_nwt;

  exp_t sb[$];
  event sample_ev;
  int   total  = 0;
  int   passed = 0;

  always #10 clock = ~clock;

  regfile #(.DATA_W(32), .WRITE_THROUGH(1)) dut_wt (
    .clock            (clock),
    .reset            (reset),
    .ctrl_writeEnable (we),
    .ctrl_writeReg    (wr),
    .data_writeReg    (wd),
    .ctrl_readRegA    (ra),
    .ctrl_readRegB    (rb),
    .data_readRegA    (a_wt),
    .data_readRegB    (b_wt)
  );

  regfile #(.DATA_W(32), .WRITE_THROUGH(0)) dut_nwt (
    .clock            (clock),
    .reset            (reset),
    .ctrl_writeEnable (we),
    .ctrl_writeReg    (wr),
    .data_writeReg    (wd),
    .ctrl_readRegA    (ra),
    .ctrl_readRegB    (rb),
    .data_readRegA    (a_nwt),
    .data_readRegB    (b_nwt)
  );

  function automatic void check(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  // Monitor: each sample request pops one expectation and checks all ports.
  initial begin
    forever begin
      @(sample_ev);
      #1;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL scoreboard_underflow: got empty queue expected entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, ".A_wt"},  a_wt,  e.a_wt);
        check({e.name, ".B_wt"},  b_wt,  e.b_wt);
        check({e.name, ".A_nwt"}, a_nwt, e.a_nwt);
        check({e.name, ".B_nwt"}, b_nwt, e.b_nwt);
      end
    end
  end

  task automatic drive(input logic w, input logic [4:0] wi, input logic [31:0] wdat,
                       input logic [4:0] ia, input logic [4:0] ib);
    we = w; wr = wi; wd = wdat; ra = ia; rb = ib;
  endtask

  task automatic probe(input string nm, input logic [31:0] ea_wt, input logic [31:0] eb_wt,
                       input logic [31:0] ea_nwt, input logic [31:0] eb_nwt);
    exp_t e;
    #1;
    e.name = nm; e.a_wt = ea_wt; e.b_wt = eb_wt; e.a_nwt = ea_nwt; e.b_nwt = eb_nwt;
    sb.push_back(e);
    -> sample_ev;
    #2;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Reset: a write with matching read index must neither bypass nor commit.
    @(negedge clock);
    drive(1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd5);
    probe("rst_bypass", 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clock);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      probe($sformatf("rst_sweep%0d", i), 32'h0, 32'h0, 32'h0, 32'h0);
    end

    // Basic write/read.
    @(negedge clock);
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd31);
    probe("wr_r5", 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
    @(negedge clock);
    drive(1'b1, 5'd31, 32'h0000_0001, 5'd5, 5'd31);
    probe("wr_r31", 32'hDEAD_BEEF, 32'h1, 32'hDEAD_BEEF, 32'h0);
    @(negedge clock);
    drive(1'b0, 5'd0, 32'h0, 5'd6, 5'd31);
    probe("rd_r6_r31", 32'h0, 32'h1, 32'h0, 32'h1);
    @(negedge clock);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
    probe("rd_r5_r6", 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h0);

    // r0 immutability.
    @(negedge clock);
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    probe("wr_r0", 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clock);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    probe("rd_r0", 32'h0, 32'h0, 32'h0, 32'h0);

    // Write-through on both ports.
    @(negedge clock);
    drive(1'b1, 5'd7, 32'h11, 5'd7, 5'd7);
    probe("wt_r7_11", 32'h11, 32'h11, 32'h0, 32'h0);
    @(negedge clock);
    drive(1'b1, 5'd7, 32'h22, 5'd7, 5'd7);
    probe("wt_r7_22", 32'h22, 32'h22, 32'h11, 32'h11);
    @(negedge clock);
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    probe("wt_r7_after", 32'h22, 32'h22, 32'h22, 32'h22);

    // Fill r1..r31 with their index, then spot-check.
    for (int i = 1; i < 32; i++) begin
      @(negedge clock);
      drive(1'b1, 5'(i), 32'(i), 5'd0, 5'd0);
    end
    @(negedge clock);
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd30);
    probe("fill_r1_r30", 32'd1, 32'd30, 32'd1, 32'd30);

    // 3 ns reset pulse between edges: outputs drop without a clock edge.
    @(negedge clock);
    drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd31);
    probe("pre_pulse", 32'd4, 32'd31, 32'd4, 32'd31);
    reset = 1'b1;
    probe("in_pulse", 32'h0, 32'h0, 32'h0, 32'h0);
    reset = 1'b0;
    probe("post_pulse", 32'h0, 32'h0, 32'h0, 32'h0);

    // Reset spanning an edge: the write on that edge is lost.
    @(negedge clock);
    drive(1'b1, 5'd9, 32'hAA, 5'd10, 5'd10);
    #8.5;
    reset = 1'b1;
    #3;
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd10);
    @(negedge clock);
    probe("rst_edge_lost", 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clock);
    drive(1'b1, 5'd9, 32'hBB, 5'd9, 5'd10);
    probe("post_rst_wr", 32'hBB, 32'h0, 32'h0, 32'h0);
    @(negedge clock);
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd10);
    probe("post_rst_rd", 32'hBB, 32'h0, 32'hBB, 32'h0);

    // Back-to-back writes to r3.
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      drive(1'b1, 5'd3, 32'(i), 5'd3, 5'd3);
      probe($sformatf("b2b_%0d", i), 32'(i), 32'(i), 32'(i - 1), 32'(i - 1));
    end
    @(negedge clock);
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    probe("b2b_final", 32'd3, 32'd3, 32'd3, 32'd3);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      total += sb.size();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
